instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
IF stage of the MIPS pipeline; the requesting side of the word-addressed instruction memory.
- Holds the PC and drives the 32-bit byte address to the memory.
- Takes the returned instruction combinationally in the same cycle.
- Registers instruction and PC+4 into the IF/ID pipeline register.
- Supports load-use stall, squash (flush) and branch/jump redirect from later stages.

Parameters:
- RESET_PC, 32'h0000_0000: PC value on reset; bits [1:0] must be 0.
- IMEM_IDX_W, 7: word-index width of the instruction memory (128 words). Used only by the optional feature and for the wrap note below.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hold PC and IF/ID contents.
- Flush  in  1  replace the IF/ID contents with a NOP bubble.
- Redirect  in  1  load PC from RedirectTarget.
- RedirectTarget  in  32  new PC (branch or jump target).
- Instruction  in  32  combinational read data from instruction memory.
- Address  out  32  fetch address to instruction memory; equals PC.
- PC  out  32  current PC register (debug/display).
- IfId_Instruction  out  32  registered instruction.
- IfId_PCPlus4  out  32  registered PC+4 of that instruction.
- IfId_Valid  out  1  1 = IF/ID holds a real fetched instruction.
- FetchCount  out  32  fetch counter (optional feature; 0 when compiled out).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - PC = RESET_PC.
  - IfId_Instruction = 32'h0 (NOP), IfId_PCPlus4 = 0, IfId_Valid = 0, FetchCount = 0.
- Address = PC, combinational. No memory latency: Instruction is valid in the same cycle.
- PC update at each rising edge, first match wins:
  1. Redirect: PC = {RedirectTarget[31:2], 2'b00}. Redirect wins over Stall; low address bits are forced to 0.
  2. Stall: PC holds.
  3. Otherwise: PC = PC + 4, modulo 2^32.
- IF/ID update at each rising edge, first match wins:
  1. Flush or Redirect: load NOP bubble (Instruction = 0, PCPlus4 = 0, Valid = 0). A redirect implicitly squashes the wrong-path fetch.
  2. Stall: hold all IF/ID fields.
  3. Otherwise: capture Instruction, PC+4 and Valid = 1.
- Simultaneous events:
  - Stall with Flush and no Redirect: PC holds, IF/ID becomes a bubble.
  - Stall with Redirect: PC is redirected, IF/ID becomes a bubble.
- First edge after reset release: IF/ID captures memory word 0; PC becomes RESET_PC + 4.
- Wrap-around:
  - PC increments past 32'hFFFF_FFFC to 0.
  - The memory uses address bits [8:2], so fetch aliases every 512 bytes. This is not flagged.
- Self-loop branch (target equals own PC) re-fetches the same word indefinitely. There is no special case.
- All outputs come from registers or from PC; there is no combinational path from Instruction to any output.

Optional Feature:
Macro: IF_FETCH_COUNT_EN.
- Defined:
  - FetchCount is a 32-bit counter, incremented on every edge where IF/ID captures a valid instruction (not Stall, not Flush, not Redirect).
  - Cleared by Reset; wraps at 2^32.
- Not defined: FetchCount is driven constant 0 and no counter logic is built.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0, INSTR_W = 32, PC_INC = 4.
  - Struct if_id_t {instr, pc_plus4, valid}. Later stages reuse it.
- One sub-module: if_id_reg, the IF/ID pipeline register with async reset, hold and flush controls.
- PC register and next-PC mux stay in instruction_fetch_stage.

Test Plan:
- Reset, then release with memory word k = k*3: edges 1–3 give IfId_Instruction 0, 3, 6, IfId_PCPlus4 4, 8, 12, PC 12.
- Stall=1 for 2 cycles at PC=8: PC stays 8, IF/ID holds instr 3; after release, the next capture is 6.
- Redirect with target 32'h0000_0043 at PC=16: PC becomes 32'h40, IfId_Valid = 0 next cycle, the following capture is word 16 (value 48).
- Stall, Flush and Redirect together (target 32'h20): PC becomes 32'h20, IF/ID becomes a bubble. Stall and Flush only: PC holds, IF/ID becomes a bubble.
- Assert Reset asynchronously mid-cycle with PC=32'h1C: PC and all IF/ID fields clear before the next edge. With IF_FETCH_COUNT_EN defined, FetchCount counts 3 after three normal fetches and clears on reset.
- PC preset via redirect to 32'hFFFF_FFFC, then free-run: next PC is 0, Address[8:2] = 0, and the capture is word 127 followed by word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction width, NOP encoding, PC step,
// and the IF/ID pipeline-register payload reused by later stages.
// Ports: none (package).
package mips_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc_plus4;
      logic               valid;
   } if_id_t;

   // Bubble loaded on reset, flush and redirect.
   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset to a bubble, hold on stall, flush to a bubble.
// Ports: clk_i/rst_i clock and active-high async reset; hold_i keeps contents;
//        flush_i loads a bubble (wins over hold_i); d_i next payload; q_o registered payload.
module if_id_reg
   import mips_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   hold_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t if_id_q;
   if_id_t if_id_d;

   always_comb begin
      if_id_d = if_id_q;
      if (flush_i) begin
         if_id_d = IF_ID_BUBBLE;
      end else if (!hold_i) begin
         if_id_d = d_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_id_q <= IF_ID_BUBBLE;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign q_o = if_id_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, next-PC mux and IF/ID register; memory read is same-cycle.
// Ports: Clk, Reset (async, active-high); Stall/Flush/Redirect/RedirectTarget controls;
//        Instruction (memory read data); Address/PC (current PC); IfId_* registered payload;
//        FetchCount counts valid captures when built with IF_FETCH_COUNT_EN, else tied to 0.
module instruction_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_IDX_W = 7
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               Redirect,
   input  logic [31:0]        RedirectTarget,
   input  logic [INSTR_W-1:0] Instruction,
   output logic [31:0]        Address,
   output logic [31:0]        PC,
   output logic [INSTR_W-1:0] IfId_Instruction,
   output logic [31:0]        IfId_PCPlus4,
   output logic               IfId_Valid,
   output logic [31:0]        FetchCount
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   if_id_t      fetch_dat;
   if_id_t      if_id_q;

   // Memory only decodes the word index, so higher PC bits alias; target low bits are dropped.
   logic [IMEM_IDX_W-1:0] unused_fetch_idx;
   logic [1:0]            unused_tgt_lo;
   assign unused_fetch_idx = pc_q[IMEM_IDX_W+1:2];
   assign unused_tgt_lo    = RedirectTarget[1:0];

   assign pc_plus4 = pc_q + PC_INC;

   // Redirect beats stall so a taken branch is never lost behind a load-use hold.
   always_comb begin
      pc_d = pc_q;
      if (Redirect) begin
         pc_d = {RedirectTarget[31:2], 2'b00};
      end else if (!Stall) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q <= {RESET_PC[31:2], 2'b00};
      end else begin
         pc_q <= pc_d;
      end
   end

   assign fetch_dat = '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};

   // A redirect squashes the wrong-path word fetched this cycle.
   if_id_reg u_if_id_reg (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .hold_i  (Stall),
      .flush_i (Flush | Redirect),
      .d_i     (fetch_dat),
      .q_o     (if_id_q)
   );

   assign Address          = pc_q;
   assign PC               = pc_q;
   assign IfId_Instruction = if_id_q.instr;
   assign IfId_PCPlus4     = if_id_q.pc_plus4;
   assign IfId_Valid       = if_id_q.valid;

`ifdef IF_FETCH_COUNT_EN
   logic [31:0] fetch_cnt_q;
   logic        capture_en;

   assign capture_en = !Stall && !Flush && !Redirect;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_cnt_q <= 32'h0;
      end else if (capture_en) begin
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

   assign FetchCount = fetch_cnt_q;
`else
   assign FetchCount = 32'h0;
`endif

endmodule
